// File: rtl/ram_bist_march_if.sv
// ram_bist_march_if
//   Master-side RAM port driven by the March C- BIST controller.
//   Parameters: WIDTH (data width), DEPTH (word count); AW is derived.
//   Signals:
//     mem_we    write enable          (master -> RAM)
//     mem_addr  word address, AW bits (master -> RAM)
//     mem_din   write data            (master -> RAM)
//     mem_dout  registered read data  (RAM -> master), valid the cycle after a read
interface ram_bist_march_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16384
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_din;
    logic [WIDTH-1:0] mem_dout;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_din,
        output mem_dout
    );
endinterface

// File: rtl/ram_bist_march.sv
// ram_bist_march
//   March C- built-in self-test controller for the single-port LUT RAM.
//   Sequence: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0),
//   followed by one DRAIN cycle for the last pipelined compare and one
//   FIN cycle that pulses done and publishes pass.
//   Ports:
//     clk, rst   clock; synchronous active-high reset
//     start      begin a run (sampled only while idle)
//     busy       high while the RAM port is owned by the sequence
//     done       one-cycle completion pulse
//     pass       result of the last run, valid from done until next start
//     bus        ram_bist_march_if.master (mem_we/mem_addr/mem_din out, mem_dout in)
//   Optional diagnostics (macro RAM_BIST_DIAG_EN):
//     fail_addr, fail_exp, fail_got, fail_elem  first mismatch captured
//     fail_cnt                                  saturating mismatch count
module ram_bist_march #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16384
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic pass,
    ram_bist_march_if.master bus
`ifdef RAM_BIST_DIAG_EN
    ,
    output logic [$clog2(DEPTH)-1:0] fail_addr,
    output logic [WIDTH-1:0]         fail_exp,
    output logic [WIDTH-1:0]         fail_got,
    output logic [2:0]               fail_elem,
    output logic [15:0]              fail_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [3:0] {
        IDLE,
        M0_W,
        M1_R,
        M1_W,
        M2_R,
        M2_W,
        M3_R,
        M3_W,
        M4_R,
        M4_W,
        M5_R,
        DRAIN,
        FIN
    } state_t;

    state_t           state_q, state_n;
    logic [AW-1:0]    addr_q, addr_n;
    logic             err_q;
    logic             rd_pend_q;

    logic             we_q, we_n;
    logic [AW-1:0]    maddr_q, maddr_n;
    logic [WIDTH-1:0] din_q, din_n;
    logic             busy_n, done_n;
    logic             rd_n;

    logic             chk;
    logic [WIDTH-1:0] exp_v;
    logic [2:0]       elem;
    logic             mis;
    logic             accept;

    assign accept = (state_q == IDLE) && start;

    assign bus.mem_we   = we_q;
    assign bus.mem_addr = maddr_q;
    assign bus.mem_din  = din_q;

    // Next state and address counter; the port outputs for the coming cycle
    // are decoded from the next state so that every output is a flop.
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = M0_W;
                    addr_n  = '0;
                end
            end
            M0_W: begin
                if (addr_q == LAST) begin
                    state_n = M1_R;
                    addr_n  = '0;
                end else begin
                    addr_n = addr_q + 1'b1;
                end
            end
            M1_R: state_n = M1_W;
            M1_W: begin
                if (addr_q == LAST) begin
                    state_n = M2_R;
                    addr_n  = '0;
                end else begin
                    state_n = M1_R;
                    addr_n  = addr_q + 1'b1;
                end
            end
            M2_R: state_n = M2_W;
            M2_W: begin
                if (addr_q == LAST) begin
                    state_n = M3_R;
                    addr_n  = LAST;
                end else begin
                    state_n = M2_R;
                    addr_n  = addr_q + 1'b1;
                end
            end
            M3_R: state_n = M3_W;
            M3_W: begin
                if (addr_q == '0) begin
                    state_n = M4_R;
                    addr_n  = LAST;
                end else begin
                    state_n = M3_R;
                    addr_n  = addr_q - 1'b1;
                end
            end
            M4_R: state_n = M4_W;
            M4_W: begin
                if (addr_q == '0) begin
                    state_n = M5_R;
                    addr_n  = '0;
                end else begin
                    state_n = M4_R;
                    addr_n  = addr_q - 1'b1;
                end
            end
            M5_R: begin
                if (addr_q == LAST) begin
                    state_n = DRAIN;
                    addr_n  = '0;
                end else begin
                    addr_n = addr_q + 1'b1;
                end
            end
            DRAIN:   state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        we_n = 1'b0;
        rd_n = 1'b0;
        case (state_n)
            M0_W, M1_W, M2_W, M3_W, M4_W: we_n = 1'b1;
            M1_R, M2_R, M3_R, M4_R, M5_R: rd_n = 1'b1;
            default: ;
        endcase
        din_n   = (state_n == M1_W || state_n == M3_W) ? '1 : '0;
        maddr_n = (we_n || rd_n) ? addr_n : '0;
        busy_n  = !(state_n == IDLE || state_n == FIN);
        done_n  = (state_n == FIN);
    end

    // Compare point: in a read/write pair the RAM holds the Mx_R data through
    // the Mx_W cycle; M5 reads are compared one cycle later via rd_pend_q.
    always_comb begin
        chk   = 1'b0;
        exp_v = '0;
        elem  = 3'd0;
        case (state_q)
            M1_W: begin chk = 1'b1; exp_v = '0; elem = 3'd1; end
            M2_W: begin chk = 1'b1; exp_v = '1; elem = 3'd2; end
            M3_W: begin chk = 1'b1; exp_v = '0; elem = 3'd3; end
            M4_W: begin chk = 1'b1; exp_v = '1; elem = 3'd4; end
            default: begin chk = rd_pend_q; exp_v = '0; elem = 3'd5; end
        endcase
        mis = chk && (bus.mem_dout != exp_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            we_q      <= 1'b0;
            maddr_q   <= '0;
            din_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state_q   <= state_n;
            addr_q    <= addr_n;
            rd_pend_q <= (state_q == M5_R);
            we_q      <= we_n;
            maddr_q   <= maddr_n;
            din_q     <= din_n;
            busy      <= busy_n;
            done      <= done_n;
            if (accept) begin
                err_q <= 1'b0;
                pass  <= 1'b0;
            end else begin
                if (mis) err_q <= 1'b1;
                // The final compare lands in DRAIN, so fold it in here.
                if (state_q == DRAIN) pass <= ~(err_q | mis);
            end
        end
    end

`ifdef RAM_BIST_DIAG_EN
    logic [AW-1:0] pend_addr_q;
    logic [AW-1:0] cmp_addr;

    assign cmp_addr = (elem == 3'd5) ? pend_addr_q : addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_addr_q <= '0;
            fail_addr   <= '0;
            fail_exp    <= '0;
            fail_got    <= '0;
            fail_elem   <= '0;
            fail_cnt    <= '0;
        end else begin
            pend_addr_q <= addr_q;
            if (accept) begin
                fail_addr <= '0;
                fail_exp  <= '0;
                fail_got  <= '0;
                fail_elem <= '0;
                fail_cnt  <= '0;
            end else if (mis) begin
                if (!err_q) begin
                    fail_addr <= cmp_addr;
                    fail_exp  <= exp_v;
                    fail_got  <= bus.mem_dout;
                    fail_elem <= elem;
                end
                if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
            end
        end
    end
`endif
endmodule
